// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder
//   Recovers the commanded duty from a PWM line driven by the motor
//   controller. The duty is the number of high clk cycles per period. It also
//   reports the measured period, and flags a line that stops toggling.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   en         decoder enable; low parks the decoder in IDLE and holds results
//   pwm_in     asynchronous PWM line
//   duty       last recovered duty (high cycles per period, saturating)
//   period     last measured period in clk cycles (0 after a stuck event)
//   duty_valid one-cycle pulse whenever duty/period are updated
//   period_ok  last measured period equalled NOM_PERIOD
//   stuck_low  line held low for TIMEOUT cycles
//   stuck_high line held high for TIMEOUT cycles
module pwm_duty_decoder #(
    parameter int DUTY_W     = 8,
    parameter int NOM_PERIOD = 256,
    parameter int TIMEOUT    = 512,
    parameter int CNT_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]  period,
    output logic              duty_valid,
    output logic              period_ok,
    output logic              stuck_low,
    output logic              stuck_high
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  NOM_C     = CNT_W'(NOM_PERIOD);
    localparam logic [DUTY_W-1:0] HI_MAX    = '1;

    logic              s1, s2, s3;
    logic              rise, fall;
    logic [1:0]        state;
    logic [CNT_W-1:0]  per_cnt;
    logic [DUTY_W-1:0] hi_cnt;

    // Input synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            duty       <= '0;
            period     <= '0;
            duty_valid <= 1'b0;
            period_ok  <= 1'b0;
            stuck_low  <= 1'b0;
            stuck_high <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (!en) begin
                state   <= ST_IDLE;
                per_cnt <= '0;
                hi_cnt  <= '0;
            end else if (rise) begin
                // A rise always starts a new measurement; from LOW it also
                // closes the previous period. It wins over a coincident timeout.
                if (state == ST_LOW) begin
                    duty       <= hi_cnt;
                    period     <= per_cnt;
                    period_ok  <= (per_cnt == NOM_C);
                    duty_valid <= 1'b1;
                    stuck_low  <= 1'b0;
                    stuck_high <= 1'b0;
                end
                state   <= ST_HIGH;
                hi_cnt  <= DUTY_W'(1);
                per_cnt <= CNT_W'(1);
            end else if (per_cnt == TO_LAST) begin
                // Counter is about to reach TIMEOUT. Once saturated it never
                // matches TO_LAST again, so IDLE cannot re-flag.
                per_cnt    <= TIMEOUT_C;
                hi_cnt     <= '0;
                state      <= ST_IDLE;
                duty       <= s2 ? HI_MAX : '0;
                period     <= '0;
                period_ok  <= 1'b0;
                stuck_low  <= ~s2;
                stuck_high <= s2;
                duty_valid <= 1'b1;
            end else begin
                if (per_cnt != TIMEOUT_C) begin
                    per_cnt <= per_cnt + CNT_W'(1);
                end
                if (state == ST_HIGH) begin
                    if (fall) begin
                        state <= ST_LOW;
                    end else if (hi_cnt != HI_MAX) begin
                        hi_cnt <= hi_cnt + DUTY_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Testbench for pwm_duty_decoder: a timestamp-based reference model predicts
// each result pulse into a queue; a monitor pops and compares on duty_valid.
module tb_pwm_duty_decoder;

    localparam int DUTY_W     = 8;
    localparam int NOM_PERIOD = 256;
    localparam int TIMEOUT    = 512;
    localparam int CNT_W      = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              pwm_in;
    logic [DUTY_W-1:0] duty;
    logic [CNT_W-1:0]  period;
    logic              duty_valid;
    logic              period_ok;
    logic              stuck_low;
    logic              stuck_high;

    pwm_duty_decoder #(
        .DUTY_W(DUTY_W),
        .NOM_PERIOD(NOM_PERIOD),
        .TIMEOUT(TIMEOUT),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .pwm_in(pwm_in),
        .duty(duty),
        .period(period),
        .duty_valid(duty_valid),
        .period_ok(period_ok),
        .stuck_low(stuck_low),
        .stuck_high(stuck_high)
    );

    always #5 clk = ~clk;

    typedef struct {
        int duty;
        int period;
        int ok;
        int sl;
        int sh;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int pulses = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference model. Time is an absolute cycle index: a period is the gap
    // between two synchronized rises, duty the count of high samples since the
    // opening rise, and a stuck event fires TIMEOUT cycles after the last
    // counter restart unless a rise came first.
    int  cyc = 0;
    int  start = 0;
    int  t0 = 0;
    int  highs = 0;
    bit  armed = 0;
    bit  ms1 = 0, ms2 = 0, ms3 = 0;

    initial begin : model
        exp_t e;
        bit   r;
        forever begin
            @(posedge clk);
            if (rst) begin
                ms1 = 0; ms2 = 0; ms3 = 0;
                armed = 0;
                start = cyc;
            end else begin
                r = ms2 && !ms3;
                if (!en) begin
                    armed = 0;
                    start = cyc;
                end else if (r) begin
                    if (armed) begin
                        e.duty   = (highs > 255) ? 255 : highs;
                        e.period = cyc - t0;
                        e.ok     = ((cyc - t0) == NOM_PERIOD) ? 1 : 0;
                        e.sl     = 0;
                        e.sh     = 0;
                        sb.push_back(e);
                    end
                    armed = 1;
                    t0    = cyc;
                    start = cyc - 1;
                    highs = 1;
                end else if (cyc - start == TIMEOUT) begin
                    e.duty   = ms2 ? 255 : 0;
                    e.period = 0;
                    e.ok     = 0;
                    e.sl     = ms2 ? 0 : 1;
                    e.sh     = ms2 ? 1 : 0;
                    sb.push_back(e);
                    armed = 0;
                end else if (armed && ms2) begin
                    highs++;
                end
                ms3 = ms2;
                ms2 = ms1;
                ms1 = pwm_in;
            end
            cyc++;
        end
    end

    initial begin : monitor
        exp_t e;
        bit   prev_v;
        prev_v = 0;
        forever begin
            @(negedge clk);
            if (duty_valid === 1'b1) begin
                pulses++;
                if (prev_v) chk("valid_back_to_back", 1, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_duty", int'(duty), e.duty);
                    chk("sb_period", int'(period), e.period);
                    chk("sb_period_ok", int'(period_ok), e.ok);
                    chk("sb_stuck_low", int'(stuck_low), e.sl);
                    chk("sb_stuck_high", int'(stuck_high), e.sh);
                end
            end
            prev_v = (duty_valid === 1'b1);
        end
    end

    // Stimulus always resumes at #1 after a rising edge.
    task automatic hold(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pwm_period(input int h, input int p);
        hold(1'b1, h);
        hold(1'b0, p - h);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_duty"}, int'(duty), 0);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_valid"}, int'(duty_valid), 0);
        chk({tag, "_ok"}, int'(period_ok), 0);
        chk({tag, "_sl"}, int'(stuck_low), 0);
        chk({tag, "_sh"}, int'(stuck_high), 0);
    endtask

    initial begin : stim
        int base;
        int p;
        int h;
        int sweep[3];
        sweep = '{1, 50, 255};
        rst = 1'b1;
        en = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        en = 1'b1;

        // Nominal 50% waveform: first rise only arms.
        base = pulses;
        repeat (4) pwm_period(128, 256);
        chk("nominal_pulses", pulses - base, 3);
        chk("nominal_duty", int'(duty), 128);
        chk("nominal_ok", int'(period_ok), 1);

        // Duty sweep then randomized periods and duties.
        foreach (sweep[i]) repeat (2) pwm_period(sweep[i], 256);
        repeat (8) begin
            p = $urandom_range(150, 400);
            h = $urandom_range(1, p - 1);
            pwm_period(h, p);
        end

        // Line stuck low after a valid period.
        hold(1'b1, 100);
        hold(1'b0, 600);
        chk("stuck_low_flag", int'(stuck_low), 1);
        chk("stuck_low_duty", int'(duty), 0);
        chk("stuck_low_period", int'(period), 0);
        base = pulses;
        hold(1'b0, 200);
        chk("stuck_low_no_repeat", pulses - base, 0);
        repeat (3) pwm_period(64, 256);
        chk("resume_stuck_low", int'(stuck_low), 0);
        chk("resume_duty", int'(duty), 64);

        // Line stuck high.
        hold(1'b1, 600);
        chk("stuck_high_flag", int'(stuck_high), 1);
        chk("stuck_high_duty", int'(duty), 255);
        chk("stuck_high_ok", int'(period_ok), 0);

        // Off-nominal period.
        hold(1'b0, 20);
        repeat (3) pwm_period(100, 200);
        hold(1'b1, 5);
        chk("p200_duty", int'(duty), 100);
        chk("p200_period", int'(period), 200);
        chk("p200_ok", int'(period_ok), 0);

        // Disable holds results and suppresses pulses.
        base = pulses;
        en = 1'b0;
        hold(1'b0, 5);
        hold(1'b1, 5);
        chk("en0_no_valid", pulses - base, 0);
        chk("en0_hold_duty", int'(duty), 100);
        chk("en0_hold_period", int'(period), 200);
        en = 1'b1;
        hold(1'b0, 30);

        // Reset mid-HIGH, then disable while the line toggles.
        hold(1'b1, 40);
        rst = 1'b1;
        hold(1'b1, 2);
        chk_zero("midrst");
        rst = 1'b0;
        en = 1'b0;
        base = pulses;
        hold(1'b0, 5);
        hold(1'b1, 5);
        chk("midrst_en0_no_valid", pulses - base, 0);
        en = 1'b1;
        hold(1'b0, 10);
        base = pulses;
        pwm_period(128, 256);
        chk("rearm_first_rise", pulses - base, 0);
        pwm_period(128, 256);
        hold(1'b1, 5);
        chk("rearm_pulses", pulses - base, 2);
        chk("rearm_duty", int'(duty), 128);
        hold(1'b0, 20);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
